// File: rtl/image_controller_pkg.sv
// Shared types and constants for the image receiver: capture and DRAM write
// engine state encodings, and the default bytes-per-DRAM-word.
package image_controller_pkg;

  localparam int BPW = 128 / 8;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FLUSH} cap_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_ACK, W_WAIT} wr_state_t;

endpackage

// File: rtl/image_receiver_if.sv
// DRAM write request bus between the image receiver (master) and the DRAM writer.
interface image_receiver_if #(
  parameter int DRAM_ADDR_WIDTH = 39,
  parameter int DRAM_DATA_WIDTH = 128
);
  logic [DRAM_ADDR_WIDTH-1:0] dram_write_addr;
  logic [7:0]                 dram_write_len;
  logic                       dram_write_en;
  logic [DRAM_DATA_WIDTH-1:0] dram_write_data;
  logic                       dram_write_busy;

  modport master (
    output dram_write_addr, dram_write_len, dram_write_en, dram_write_data,
    input  dram_write_busy
  );

  modport slave (
    input  dram_write_addr, dram_write_len, dram_write_en, dram_write_data,
    output dram_write_busy
  );
endinterface

// File: rtl/image_capture_fifo.sv
// Packed-word FIFO with synchronous active-low reset; pushes while full are discarded.
module image_capture_fifo #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 64
) (
  input  logic                  clk_pixel,
  input  logic                  fifo_reset_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  push, pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_pixel) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk_pixel) begin
    if (!fifo_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/image_receiver.sv
// Captures one grayscale frame per arm, packs pixels into DRAM words and writes
// them to alternating ping-pong buffers, one single-word request at a time.
module image_receiver
  import image_controller_pkg::*;
#(
  parameter int BIT_WIDTH       = 12,
  parameter int BIT_HEIGHT      = 11,
  parameter int DRAM_ADDR_WIDTH = 39,
  parameter int DRAM_DATA_WIDTH = 128,
  parameter int FIFO_DEPTH      = 64
) (
  input  logic                       clk_pixel,
  input  logic                       image_receiver_reset_n,
  input  logic                       capture_start,
  input  logic                       frame_start,
  input  logic                       pixel_valid,
  input  logic [7:0]                 pixel_data,
  input  logic [BIT_WIDTH-1:0]       image_width,
  input  logic [BIT_HEIGHT-1:0]      image_height,
  input  logic [DRAM_ADDR_WIDTH-1:0] base_addr_0,
  input  logic [DRAM_ADDR_WIDTH-1:0] base_addr_1,
  image_receiver_if.master           dram,
  output logic                       capture_busy,
  output logic                       frame_done,
  output logic                       frame_buffer_sel,
  output logic                       overflow
);
  localparam int WORD_BYTES = DRAM_DATA_WIDTH / 8;
  localparam int BYTE_IDX_W = $clog2(WORD_BYTES);
  localparam int CNT_W      = BIT_WIDTH + BIT_HEIGHT;
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(WORD_BYTES - 1);

  cap_state_t cap_state, cap_next;
  wr_state_t  wr_state, wr_next;

  logic [CNT_W-1:0]           pix_cnt, pix_total, frame_pixels, cnt_base, tot_base;
  logic [BYTE_IDX_W-1:0]      byte_idx, bidx;
  logic [DRAM_DATA_WIDTH-1:0] pack_word, fifo_head;
  logic [DRAM_ADDR_WIDTH-1:0] word_index, base_addr;
  logic                       word_vld, buf_next, buf_cur;
  logic                       start_frame, zero_frame, accept, last_pixel, flush_done;
  logic                       fifo_full, fifo_empty, fifo_rd;

  assign frame_pixels = CNT_W'(image_width) * CNT_W'(image_height);
  assign zero_frame   = (image_width == '0) || (image_height == '0);
  assign start_frame  = (cap_state == ARMED) && frame_start;
  // The frame_start cycle itself carries pixel 0, so ARMED accepts on that cycle.
  assign accept       = pixel_valid && ((cap_state == CAPTURE) || (start_frame && !zero_frame));
  assign cnt_base     = (cap_state == CAPTURE) ? pix_cnt   : '0;
  assign tot_base     = (cap_state == CAPTURE) ? pix_total : frame_pixels;
  assign bidx         = (cap_state == CAPTURE) ? byte_idx  : '0;
  assign last_pixel   = accept && ((cnt_base + CNT_W'(1)) == tot_base);
  assign flush_done   = (cap_state == FLUSH) && fifo_empty && !word_vld && (wr_state == W_IDLE);
  assign base_addr    = buf_cur ? base_addr_1 : base_addr_0;

  always_comb begin
    cap_next     = cap_state;
    capture_busy = (cap_state != IDLE);
    frame_done   = flush_done;
    case (cap_state)
      IDLE:    if (capture_start) cap_next = ARMED;
      ARMED:   if (frame_start) cap_next = (zero_frame || last_pixel) ? FLUSH : CAPTURE;
      CAPTURE: if (last_pixel) cap_next = FLUSH;
      FLUSH:   if (flush_done) cap_next = IDLE;
      default: cap_next = IDLE;
    endcase
  end

  // Pack stage: a completed or final partial word is staged in pack_word and
  // pushed one cycle later; writing byte 0 clears the rest, giving zero padding.
  always_ff @(posedge clk_pixel) begin
    if (!image_receiver_reset_n) begin
      cap_state        <= IDLE;
      pix_cnt          <= '0;
      pix_total        <= '0;
      byte_idx         <= '0;
      pack_word        <= '0;
      word_vld         <= 1'b0;
      buf_next         <= 1'b0;
      buf_cur          <= 1'b0;
      frame_buffer_sel <= 1'b0;
      overflow         <= 1'b0;
    end else begin
      cap_state <= cap_next;
      word_vld  <= accept && ((bidx == LAST_BYTE) || last_pixel);
      if (start_frame) begin
        pix_total <= frame_pixels;
        if (!zero_frame) begin
          buf_cur  <= buf_next;
          buf_next <= ~buf_next;
        end
      end
      if (accept) begin
        pix_cnt  <= last_pixel ? '0 : cnt_base + CNT_W'(1);
        byte_idx <= (last_pixel || (bidx == LAST_BYTE)) ? '0 : bidx + BYTE_IDX_W'(1);
        if (bidx == '0) pack_word <= {{(DRAM_DATA_WIDTH-8){1'b0}}, pixel_data};
        else            pack_word[8*bidx +: 8] <= pixel_data;
      end
      if (word_vld && fifo_full)                  overflow <= 1'b1;
      else if ((cap_state == IDLE) && capture_start) overflow <= 1'b0;
      if (flush_done) frame_buffer_sel <= buf_cur;
    end
  end

  image_capture_fifo #(
    .DATA_WIDTH (DRAM_DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_pixel    (clk_pixel),
    .fifo_reset_n (image_receiver_reset_n),
    .wr_en        (word_vld),
    .wr_data      (pack_word),
    .rd_en        (fifo_rd),
    .rd_data      (fifo_head),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

  always_comb begin
    wr_next = wr_state;
    fifo_rd = 1'b0;
    case (wr_state)
      W_IDLE:  if (!fifo_empty && !dram.dram_write_busy) wr_next = W_ISSUE;
      W_ISSUE: begin
        fifo_rd = 1'b1;
        wr_next = W_ACK;
      end
      W_ACK:   wr_next = W_WAIT;
      W_WAIT:  if (!dram.dram_write_busy) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  // Issue stage: request fields are registered on entry to W_ISSUE so the
  // enable is high for exactly the W_ISSUE cycle.
  always_ff @(posedge clk_pixel) begin
    if (!image_receiver_reset_n) begin
      wr_state             <= W_IDLE;
      word_index           <= '0;
      dram.dram_write_en   <= 1'b0;
      dram.dram_write_addr <= '0;
      dram.dram_write_data <= '0;
      dram.dram_write_len  <= '0;
    end else begin
      wr_state            <= wr_next;
      dram.dram_write_en  <= (wr_next == W_ISSUE);
      dram.dram_write_len <= '0;
      if ((wr_state == W_IDLE) && (wr_next == W_ISSUE)) begin
        dram.dram_write_addr <= base_addr + (word_index << BYTE_IDX_W);
        dram.dram_write_data <= fifo_head;
      end
      if (start_frame)  word_index <= '0;
      else if (fifo_rd) word_index <= word_index + DRAM_ADDR_WIDTH'(1);
    end
  end
endmodule

// File: doc/image_receiver.md
IMAGE_RECEIVER -- requirements
Module: image_receiver

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 12, width of image_width.
REQ-002 SHALL have parameter BIT_HEIGHT, default 11, width of image_height.
REQ-003 SHALL have parameter DRAM_ADDR_WIDTH, default 39, DRAM byte address width.
REQ-004 SHALL have parameter DRAM_DATA_WIDTH, default 128, DRAM word width; bytes per word BPW = DRAM_DATA_WIDTH/8.
REQ-005 SHALL have parameter FIFO_DEPTH, default 64, packed-word FIFO depth.
REQ-006 SHALL have one clock and a synchronous active-low reset, in that order: clk_pixel (in, 1, sole clock) and image_receiver_reset_n (in, 1, synchronous, active-low).
REQ-007 capture_start  in  1  pulse; arms capture of next frame.
REQ-008 frame_start  in  1  pulse coincident with first pixel of a frame.
REQ-009 pixel_valid  in  1  pixel_data valid this cycle.
REQ-010 pixel_data  in  8  grayscale pixel.
REQ-011 image_width / image_height  in  BIT_WIDTH / BIT_HEIGHT  frame size, sampled at frame_start.
REQ-012 base_addr_0 / base_addr_1  in  DRAM_ADDR_WIDTH each  ping-pong buffer bases, BPW-aligned.
REQ-013 dram_write_addr / dram_write_len / dram_write_en / dram_write_data  out  DRAM_ADDR_WIDTH / 8 / 1 / DRAM_DATA_WIDTH  write request.
REQ-014 dram_write_busy  in  1  DRAM writer busy; rises the cycle after dram_write_en, falls when the write completes.
REQ-015 capture_busy  out  1  frame capture in progress.
REQ-016 frame_done  out  1  one-cycle pulse, last word of frame accepted by DRAM.
REQ-017 frame_buffer_sel  out  1  buffer index of last completed frame.
REQ-018 overflow  out  1  sticky; a pixel was dropped.

Function
REQ-019 Capture FSM SHALL use states IDLE, ARMED, CAPTURE, FLUSH: IDLE->ARMED on capture_start; ARMED->CAPTURE on frame_start; CAPTURE->FLUSH when pixel count reaches image_width*image_height; FLUSH->IDLE when the FIFO is empty and the write engine is idle.
REQ-020 Pixels SHALL be accepted only in CAPTURE, including the frame_start cycle; pixel_valid elsewhere SHALL be ignored.
REQ-021 Packing SHALL place pixel k of each word in bits [8k+7:8k]; the first pixel of a frame goes to byte 0.
REQ-022 Write timing: a word SHALL be written to the FIFO in the cycle after its BPW-th byte arrives.
REQ-023 Frame end: if the pixel count is not a multiple of BPW, the final partial word SHALL be zero-padded and pushed on entering FLUSH.
REQ-024 FIFO full on a word push: the word SHALL be dropped, overflow set, and the pixel counter still advanced, so frame end is unaffected.
REQ-025 Write engine SHALL use states W_IDLE, W_ISSUE, W_ACK, W_WAIT: W_IDLE->W_ISSUE when the FIFO is not empty and dram_write_busy=0.
REQ-026 In W_ISSUE the engine SHALL pulse dram_write_en for exactly one cycle, with dram_write_len=0, addr = base + word_index*BPW and data = FIFO head, then pop the FIFO.
REQ-027 The engine SHALL move W_ACK->W_WAIT unconditionally and W_WAIT->W_IDLE when dram_write_busy=0.
REQ-028 word_index SHALL reset to 0 at each frame_start in ARMED.
REQ-029 Address arithmetic SHALL be DRAM_ADDR_WIDTH wide, wrapping modulo 2^DRAM_ADDR_WIDTH.
REQ-030 Buffer selection SHALL latch at ARMED->CAPTURE, alternating 0,1,0,... starting at 0 after reset.
REQ-031 On FLUSH->IDLE, frame_done SHALL pulse and frame_buffer_sel SHALL take the latched buffer index.
REQ-032 capture_busy SHALL be 1 in ARMED, CAPTURE and FLUSH.
REQ-033 capture_start outside IDLE SHALL be ignored.
REQ-034 frame_start in CAPTURE or FLUSH SHALL be ignored; the current frame completes.
REQ-035 capture_start in IDLE SHALL clear overflow.
REQ-036 image_width=0 or image_height=0 SHALL go ARMED->FLUSH directly, write nothing, and pulse frame_done.

Reset
REQ-037 While image_receiver_reset_n=0 at a clk_pixel edge, all FSMs SHALL go to IDLE/W_IDLE and the FIFO SHALL be flushed.
REQ-038 Reset SHALL clear the pack register, counters, word_index and buffer toggle.
REQ-039 All outputs SHALL reset to 0, including dram_write_data and dram_write_addr.
REQ-040 Reset mid-write SHALL abandon the outstanding request; no further dram_write_en until a new capture.

Structure
REQ-041 Shared package image_controller_pkg SHALL hold both FSM state enums and the BPW constant.
REQ-042 One sub-module, image_capture_fifo (DRAM_DATA_WIDTH x FIFO_DEPTH, synchronous reset, full/empty), SHALL be used.

Verification
REQ-043 4x4 frame, base_addr_0=0x1000, busy 3 cycles -> writes 0x1000 data bytes 0..15 = pixels in order; frame_done once; frame_buffer_sel=0.
REQ-044 Two captures, base_addr_1=0x8000 -> second frame written at 0x8000; frame_buffer_sel=1.
REQ-045 3x3 frame -> one write; bytes 9..15 zero.
REQ-046 dram_write_busy held 1 for 2000 cycles, 64x64 frame -> overflow=1 and frame_done still pulses; next capture_start clears overflow.
REQ-047 Reset asserted in CAPTURE after 5 words -> all outputs 0 next cycle; no dram_write_en afterwards without capture_start.
REQ-048 image_width=0 -> no dram_write_en; frame_done one cycle after frame_start.
